// File: rtl/arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared constants, state type and the rotating first-set search
//             used by the eight-requester round-robin arbiter.
//  Contents : N_REQ, IDX_W, arb_state_t, rr_first()
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Search vec for the first set bit starting at index 'start' and moving
  // upward with natural 3-bit wrap.  Returns {found, index}.  The loop walks
  // from the farthest offset back to the nearest so the nearest hit is the
  // last one written and therefore wins.
  function automatic logic [IDX_W:0] rr_first(input logic [N_REQ-1:0] vec,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] k;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + IDX_W'(i);
      if (vec[k]) res = {1'b1, k};
    end
    return res;
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/onehot_dec3to8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : onehot_dec3to8
//  Purpose  : Combinational 3-to-8 one-hot decoder.
//  Ports    : idx    - in,  3-bit binary index
//             onehot - out, 8-bit one-hot vector, bit idx set
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_dec3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  for (genvar i = 0; i < N_REQ; i++) begin : g_dec
    assign onehot[i] = (idx == IDX_W'(i));
  end

endmodule : onehot_dec3to8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter8
//  Purpose  : Eight-requester round-robin arbiter.  Grants one requester at a
//             time, holds the grant until the owner releases it (done or
//             request withdrawn), then rotates priority and re-arbitrates in
//             the same cycle with the previous owner masked out.
//  Option   : RR_ARBITER8_TIMEOUT_EN - when defined, an 8-bit hold counter
//             force-releases a grant after HOLD_MAX cycles and pulses
//             'timeout'.  Undefined: no counter, 'timeout' tied low.
//  Ports    : clk       - in,  clock (rising edge)
//             rst_n     - in,  asynchronous active-low reset
//             req       - in,  8-bit request vector
//             done      - in,  owner releases its grant
//             gnt       - out, registered one-hot grant (0 when idle)
//             gnt_idx   - out, registered owner index (holds when idle)
//             gnt_valid - out, grant active
//             timeout   - out, one-cycle pulse on forced release
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
  parameter int N_REQ    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  import arb_pkg::IDX_W;
  import arb_pkg::arb_state_t;
  import arb_pkg::IDLE;
  import arb_pkg::GRANT;
  import arb_pkg::rr_first;

  // Elaboration-time parameter guards.
  if (N_REQ != 8) begin : g_bad_n_req
    $error("rr_arbiter8: N_REQ must be 8");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter8: HOLD_MAX must be in 1..255");
  end

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] prio, prio_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic [7:0]       dec_out;
  logic [7:0]       gnt_nxt;
  logic [IDX_W:0]   pick;
  logic             owner_req;
  logic             hold_hit;
  logic             rel;
  logic             new_grant;
  logic             to_nxt;

  assign owner_req = req[gnt_idx];

`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [7:0] hold_cnt;
  // Counter is 0 in the first grant cycle, so matching HOLD_MAX-1 releases
  // at the end of cycle HOLD_MAX.
  assign hold_hit = (hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign hold_hit = 1'b0;
`endif

  assign rel = (state == GRANT) && (done || !owner_req || hold_hit);

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
    new_grant = 1'b0;
    to_nxt    = 1'b0;
    pick      = '0;
    case (state)
      IDLE: begin
        pick = rr_first(req, prio);
        if (pick[IDX_W]) begin
          idx_nxt   = pick[IDX_W-1:0];
          valid_nxt = 1'b1;
          new_grant = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          prio_nxt = gnt_idx + 3'd1;
          // gnt is the registered one-hot of the current owner, so it doubles
          // as the mask that keeps the releasing owner out of this round.
          pick = rr_first(req & ~gnt, gnt_idx + 3'd1);
          // A forced release reports only when nothing else released it.
          to_nxt = hold_hit && !done && owner_req;
          if (pick[IDX_W]) begin
            idx_nxt   = pick[IDX_W-1:0];
            new_grant = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  onehot_dec3to8 u_dec (
    .idx    (idx_nxt),
    .onehot (dec_out)
  );

  assign gnt_nxt = valid_nxt ? dec_out : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= '0;
      gnt_idx   <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      gnt_idx   <= idx_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
    end
  end

`ifdef RR_ARBITER8_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_nxt;
      if (new_grant)
        hold_cnt <= '0;
      else if (state == GRANT)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
  // new_grant and to_nxt only feed the hold counter.
  logic unused_ok;
  assign unused_ok = &{1'b0, new_grant, to_nxt};
`endif

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter8
//  Purpose  : Self-checking bench for rr_arbiter8: directed vector table plus
//             hand-written reset, timeout/hold and async-reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(
    .N_REQ    (8),
    .HOLD_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] gnt;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] idx,
                           input logic valid, input logic [7:0] g, input logic to);
    check({tag, ".gnt_idx"},   {5'b0, gnt_idx},   {5'b0, idx});
    check({tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, valid});
    check({tag, ".gnt"},       gnt,               g);
    check({tag, ".timeout"},   {7'b0, timeout},   {7'b0, to});
  endtask

  initial begin
    // Starts with owner 0 granted and prio 0 (state right after reset).
    vecs[0]  = '{8'h20, 1'b0, 3'd5, 1'b1, 8'h20}; // owner 0 withdraws -> 5
    vecs[1]  = '{8'h20, 1'b1, 3'd5, 1'b0, 8'h00}; // 5 released, masked -> idle
    vecs[2]  = '{8'h00, 1'b0, 3'd5, 1'b0, 8'h00}; // idle holds last index
    vecs[3]  = '{8'hFF, 1'b0, 3'd6, 1'b1, 8'h40}; // prio 6 after releasing 5
    vecs[4]  = '{8'hFF, 1'b1, 3'd7, 1'b1, 8'h80};
    vecs[5]  = '{8'hFF, 1'b1, 3'd0, 1'b1, 8'h01};
    vecs[6]  = '{8'hFF, 1'b1, 3'd1, 1'b1, 8'h02};
    vecs[7]  = '{8'hFF, 1'b1, 3'd2, 1'b1, 8'h04};
    vecs[8]  = '{8'hFF, 1'b1, 3'd3, 1'b1, 8'h08};
    vecs[9]  = '{8'hFF, 1'b1, 3'd4, 1'b1, 8'h10};
    vecs[10] = '{8'hFF, 1'b1, 3'd5, 1'b1, 8'h20};
    vecs[11] = '{8'hFF, 1'b1, 3'd6, 1'b1, 8'h40};
    vecs[12] = '{8'hFF, 1'b1, 3'd7, 1'b1, 8'h80};
    vecs[13] = '{8'hFF, 1'b1, 3'd0, 1'b1, 8'h01}; // rotation wraps 7 -> 0
    vecs[14] = '{8'h40, 1'b1, 3'd6, 1'b1, 8'h40};
    vecs[15] = '{8'h41, 1'b1, 3'd0, 1'b1, 8'h01}; // 6 masked, wrap to 0
    vecs[16] = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04}; // owner 0 withdraws -> 2
    vecs[17] = '{8'h04, 1'b0, 3'd2, 1'b1, 8'h04}; // grant held
    vecs[18] = '{8'h00, 1'b1, 3'd2, 1'b0, 8'h00}; // done + drop = one release
    vecs[19] = '{8'h08, 1'b0, 3'd3, 1'b1, 8'h08};
    vecs[20] = '{8'h08, 1'b1, 3'd3, 1'b0, 8'h00}; // released owner cannot win
    vecs[21] = '{8'h08, 1'b0, 3'd3, 1'b1, 8'h08}; // eligible again next cycle

    // Reset with all requests high.
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset", 3'd0, 1'b1, 8'h01, 1'b0);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].req, vecs[i].done);
      check_all($sformatf("vec%0d", i), vecs[i].idx, vecs[i].valid, vecs[i].gnt, 1'b0);
    end

    // Hold/timeout: go idle (prio 4), then req 8'h03 wraps to owner 0.
    step(8'h00, 1'b0);
    check_all("to_idle", 3'd3, 1'b0, 8'h00, 1'b0);
    step(8'h03, 1'b0);
    check_all("to_grant0", 3'd0, 1'b1, 8'h01, 1'b0);
`ifdef RR_ARBITER8_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step(8'h03, 1'b0);
      check_all($sformatf("to_hold%0d", i), 3'd0, 1'b1, 8'h01, 1'b0);
    end
    step(8'h03, 1'b0);
    check_all("to_fire", 3'd1, 1'b1, 8'h02, 1'b1);
    step(8'h03, 1'b0);
    check_all("to_after", 3'd1, 1'b1, 8'h02, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      step(8'h03, 1'b0);
      check_all($sformatf("hold%0d", i), 3'd0, 1'b1, 8'h01, 1'b0);
    end
`endif

    // Async reset in the middle of a grant to owner 3.
    step(8'h08, 1'b0);
    check_all("pre_arst", 3'd3, 1'b1, 8'h08, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst", 3'd0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_arst", 3'd3, 1'b1, 8'h08, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_arbiter8
`default_nettype wire
